// File: rtl/carrier_pkg.sv
// rtl/carrier_pkg.sv - Shared waveform mode encodings for the carrier generator
package carrier_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SAW    = 2'd3
  } wave_mode_e;

endpackage

// File: rtl/sine_qlut.sv
// rtl/sine_qlut.sv - Quarter-wave sine magnitude table with registered read
module sine_qlut #(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-2:0] data
);

  localparam int  DEPTH = 2 ** LUT_AW;
  localparam int  MAXV  = 2 ** (DATA_W - 1) - 1;
  localparam real AMP   = real'(2 ** (DATA_W - 1)) - 0.5;
  localparam real PI    = 3.14159265358979323846;

  logic [DATA_W-2:0] rom [DEPTH];

  // Half-step sample points keep the table symmetric around each quadrant
  // boundary; the clamp stops a rounded peak from spilling into the midscale bit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG = PI / 2.0 * (real'(i) + 0.5) / real'(DEPTH);
    localparam int  RAW = $rtoi(AMP * $sin(ANG) + 0.5);
    localparam int  VAL = (RAW > MAXV) ? MAXV : RAW;
    assign rom[i] = (DATA_W - 1)'(VAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/dds_carrier_gen.sv
// rtl/dds_carrier_gen.sv - Phase-accumulator carrier generator driving a clocked DAC
module dds_carrier_gen
  import carrier_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int DA_DIV  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic               phase_clr,
  output logic               clk_DA,
  output logic               blank_DA_n,
  output logic               sync_DA_n,
  output logic [DATA_W-1:0]  dataout,
  output logic               wrap
);

  localparam int                CNT_W    = $clog2(DA_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DA_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DA_DIV / 2);
  localparam logic [DATA_W-1:0] MID      = DATA_W'(1) << (DATA_W - 1);
  localparam logic [DATA_W-1:0] MID_M1   = MID - DATA_W'(1);

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_reg;
  logic               clr_pend;
  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] p;
  logic [LUT_AW-1:0]  lut_addr;
  logic [DATA_W-2:0]  lut_q;
  logic [DATA_W-1:0]  tri_t;
  wave_mode_e         mode_r;
  logic               msb_r;
  logic               en_d1;
  logic [DATA_W-1:0]  tri_r;
  logic [DATA_W-1:0]  saw_r;
  logic [DATA_W-1:0]  sample;
  logic               unused_p;

  assign tick      = enable && (cnt == CNT_LAST);
  assign clk_DA    = enable && (cnt >= CNT_HALF);
  assign sync_DA_n = 1'b1;

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_reg};

  // A clear strobe is remembered until the next tick so the phase jump lands
  // on a sample boundary; the clearing tick skips the add and cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      ftw_reg  <= '0;
      clr_pend <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ftw_load) begin
        ftw_reg <= ftw;
      end
      if (tick) begin
        clr_pend <= 1'b0;
        if (clr_pend || phase_clr) begin
          acc <= '0;
        end else begin
          acc  <= acc_sum[PHASE_W-1:0];
          wrap <= acc_sum[PHASE_W];
        end
      end else if (phase_clr) begin
        clr_pend <= 1'b1;
      end
    end
  end

  assign p        = acc + phase_off;
  assign lut_addr = p[PHASE_W-2] ? ~p[PHASE_W-3 -: LUT_AW] : p[PHASE_W-3 -: LUT_AW];
  assign tri_t    = p[PHASE_W-2 -: DATA_W];
  assign unused_p = ^p[PHASE_W-2-DATA_W:0];

  sine_qlut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_sine_qlut (
    .clk   (clk),
    .reset (reset),
    .addr  (lut_addr),
    .data  (lut_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= SINE;
      msb_r  <= 1'b0;
      tri_r  <= '0;
      saw_r  <= '0;
      en_d1  <= 1'b0;
    end else begin
      mode_r <= wave_mode_e'(mode);
      msb_r  <= p[PHASE_W-1];
      tri_r  <= p[PHASE_W-1] ? ~tri_t : tri_t;
      saw_r  <= p[PHASE_W-1 -: DATA_W];
      en_d1  <= enable;
    end
  end

  // The negative half-wave mirrors below M-1 so the two halves sum to all-ones.
  always_comb begin
    sample = MID;
    case (mode_r)
      SINE:    sample = msb_r ? (MID_M1 - {1'b0, lut_q}) : (MID + {1'b0, lut_q});
      SQUARE:  sample = msb_r ? '0 : '1;
      TRI:     sample = tri_r;
      SAW:     sample = saw_r;
      default: sample = MID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_DA_n <= 1'b0;
      dataout    <= MID;
    end else begin
      blank_DA_n <= en_d1;
      dataout    <= en_d1 ? sample : MID;
    end
  end

endmodule

// File: doc/dds_carrier_gen.md
DDS_CARRIER_GEN -- requirements
Module: dds_carrier_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning DAC sample width.
REQ-002 SHALL have parameter PHASE_W, default 16, meaning phase accumulator width (>= DATA_W+2).
REQ-003 SHALL have parameter LUT_AW, default 6, meaning quarter-wave sine table address width (2^LUT_AW entries).
REQ-004 SHALL have parameter DA_DIV, default 4, meaning clk cycles per DAC sample (even, >= 4).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  run; 0 holds phase and blanks DAC.
REQ-008 SHALL have port mode  in  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-009 SHALL have port ftw  in  PHASE_W  frequency tuning word, captured on ftw_load.
REQ-010 SHALL have port ftw_load  in  1  one-cycle strobe capturing ftw.
REQ-011 SHALL have port phase_off  in  PHASE_W  phase offset added before lookup.
REQ-012 SHALL have port phase_clr  in  1  one-cycle strobe zeroing accumulator.
REQ-013 SHALL have port clk_DA  out  1  DAC sample clock.
REQ-014 SHALL have port blank_DA_n  out  1  DAC blank, active low.
REQ-015 SHALL have port sync_DA_n  out  1  DAC sync, active low.
REQ-016 SHALL have port dataout  out  DATA_W  offset-binary sample, midscale M = 2^(DATA_W-1).
REQ-017 SHALL have port wrap  out  1  one-cycle pulse on accumulator overflow.

Function
REQ-018 SHALL run divider cnt 0..DA_DIV-1 while enable=1; tick = (cnt==DA_DIV-1); cnt held at 0 while enable=0.
REQ-019 SHALL set clk_DA=1 iff enable=1 and cnt >= DA_DIV/2.
REQ-020 SHALL on tick update acc <= acc + ftw_reg modulo 2^PHASE_W; wrap=1 in the following cycle iff carry out.
REQ-021 SHALL capture ftw into ftw_reg on ftw_load regardless of enable; the new value is used from the first tick after capture; ftw_load coincident with a tick uses the old value for that tick.
REQ-022 SHALL on phase_clr set acc to 0 at the next tick (acc=0, no add, no wrap); phase_clr and ftw_load together both take effect.
REQ-023 SHALL look up p = acc + phase_off (mod 2^PHASE_W); mode and phase_off sampled at lookup, no buffering.
REQ-024 SHALL update dataout exactly 2 clk cycles after the tick edge (accumulate, lookup register, output register), i.e. stable before clk_DA rises.
REQ-025 SHALL produce sine from a = p[PHASE_W-3 -: LUT_AW], quadrant q = p[PHASE_W-1:PHASE_W-2]: q0 M+L[a], q1 M+L[~a], q2 M-1-L[a], q3 M-1-L[~a]; L[i] = round((M-0.5)*sin(pi/2*(i+0.5)/2^LUT_AW)).
REQ-026 SHALL produce square = all-ones when p MSB=0, else 0.
REQ-027 SHALL produce triangle: t = p[PHASE_W-2 -: DATA_W]; output t when MSB=0, bitwise ~t when MSB=1.
REQ-028 SHALL produce sawtooth = p[PHASE_W-1 -: DATA_W].
REQ-029 SHALL drive blank_DA_n = enable delayed 2 cycles; dataout forced to M while blank_DA_n=0.
REQ-030 SHALL hold sync_DA_n = 1 permanently.
REQ-031 SHALL on enable 1->0 freeze acc and ftw_reg; on 0->1 resume from frozen phase, first tick DA_DIV cycles later.

Reset
REQ-032 SHALL on reset (next edge, also mid-operation) set acc=0, ftw_reg=0, cnt=0, clk_DA=0, blank_DA_n=0, sync_DA_n=1, dataout=M, wrap=0, pipeline cleared; reset overrides ftw_load and phase_clr.

Structure
REQ-033 SHALL place mode encoding constants (SINE, SQUARE, TRI, SAW) in shared package carrier_pkg.
REQ-034 SHALL implement the quarter-wave table as sub-module sine_qlut (registered read, LUT_AW in, DATA_W-1 out), contents computed from parameters.
REQ-035 SHALL contain no other clocks, latches, or multicycle paths.

Verification
REQ-036 SHALL verify: defaults, mode=3, ftw=0x0100, enable=1 -> dataout 0x00,0x01,0x02,... one step per 4 clk; wrap every 1024 clk.
REQ-037 SHALL verify: mode=1, ftw=0x8000 -> dataout alternates 0xFF,0x00 per sample; wrap every 8 clk.
REQ-038 SHALL verify: mode=0, ftw=0x0100, phase_off=0 -> first sample 0x82, peak 0xFF, trough 0x00, sequence symmetric about 0x80/0x7F.
REQ-039 SHALL verify: mode=2, ftw=0x0200 -> 0x00,0x04,...,0xFC,0xFF,0xFB,...,0x03, repeating.
REQ-040 SHALL verify: ftw_load with new ftw mid-run plus phase_clr same cycle -> next tick acc=0, following tick acc=new ftw.
REQ-041 SHALL verify: reset asserted mid-run -> next cycle dataout=0x80, blank_DA_n=0, clk_DA=0, wrap=0; enable=0 -> phase frozen and resumes unchanged.
